host_bus_ctrl: RTL and testbench

// Parametrised Z80 host bus controller; sits between z80_top_direct_n and board peripherals.

---
 rtl/host_bus_if.sv | 39 +++
 rtl/host_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_host_bus_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/host_bus_if.sv
`default_nettype none
// ============================================================================
// host_bus_if : Z80 bus pins plus RAM/IO peripheral side of host_bus_ctrl
// Rev 1.0
// ============================================================================
interface host_bus_if #(
  parameter int RAM_AW = 14,
  parameter int NUM_IO = 4
);
  logic [15:0]         A;
  logic                nMREQ;
  logic                nIORQ;
  logic                nRD;
  logic                nWR;
  logic                nM1;
  logic                nRFSH;
  logic                nWAIT;
  logic [7:0]          d_out;
  logic                d_oe;
  logic [RAM_AW-1:0]   ram_addr;
  logic                ram_we;
  logic [7:0]          ram_rdata;
  logic [NUM_IO-1:0]   io_sel;
  logic                io_rd;
  logic                io_wr;
  logic [8*NUM_IO-1:0] io_rdata;
  logic                bus_err;

  modport slave (
    input  A, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, ram_rdata, io_rdata,
    output nWAIT, d_out, d_oe, ram_addr, ram_we, io_sel, io_rd, io_wr, bus_err
  );

  modport master (
    output A, nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, ram_rdata, io_rdata,
    input  nWAIT, d_out, d_oe, ram_addr, ram_we, io_sel, io_rd, io_wr, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/host_bus_ctrl.sv
`default_nettype none
// ============================================================================
// host_bus_ctrl : Z80 bus cycle decoder, wait-state inserter and strobe gen
// Rev 1.0
// ============================================================================
module host_bus_ctrl #(
  parameter int         RAM_AW   = 14,
  parameter int         NUM_IO   = 4,
  parameter logic [7:0] IO_BASE  = 8'h00,
  parameter int         MEM_WAIT = 0,
  parameter int         IO_WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  host_bus_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [16:0] RAM_LIMIT = 17'(1) << RAM_AW;

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt, wait_cnt_nxt;
  logic [RAM_AW-1:0]   addr_q;
  logic                is_read, is_mem, mapped;
  logic [NUM_IO-1:0]   io_sel_q;
  logic [7:0]          d_out_q;
  logic                d_oe_q;
  logic                ill_seen, ill_err;

  logic                mem_kind, io_kind, req, start, illegal;
  logic                mem_hit, io_hit;
  logic [8:0]          port_off;
  logic [NUM_IO-1:0]   sel_new;
  logic [7:0]          io_byte;
  logic [3:0]          wait_load;

  // Refresh and interrupt-acknowledge cycles match neither kind and are ignored.
  assign mem_kind = !bus.nMREQ && bus.nRFSH;
  assign io_kind  = !bus.nIORQ && bus.nM1;
  assign req      = (!bus.nMREQ || !bus.nIORQ) && (mem_kind || io_kind);
  assign start    = req && (!bus.nRD ^ !bus.nWR);
  assign illegal  = req && !bus.nRD && !bus.nWR;

  assign mem_hit   = {1'b0, bus.A} < RAM_LIMIT;
  assign port_off  = {1'b0, bus.A[15:8]} - {1'b0, IO_BASE};
  assign io_hit    = !port_off[8] && (port_off < 9'(NUM_IO));
  assign sel_new   = io_hit ? (NUM_IO'(1) << port_off[3:0]) : '0;
  assign wait_load = mem_kind ? 4'(MEM_WAIT) : 4'(IO_WAIT);

  always_comb begin
    io_byte = 8'h00;
    for (int p = 0; p < NUM_IO; p++) begin
      if (io_sel_q[p]) io_byte = io_byte | bus.io_rdata[8*p +: 8];
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    bus.nWAIT    = 1'b1;
    bus.ram_we   = 1'b0;
    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    bus.bus_err  = ill_err;
    bus.ram_addr = (state == ST_IDLE) ? bus.A[RAM_AW-1:0] : addr_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (wait_load != 4'd0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = wait_load;
          end else begin
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        bus.nWAIT = 1'b0;
        if (wait_cnt <= 4'd1) state_nxt = ST_ACCESS;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      ST_ACCESS: begin
        state_nxt   = ST_HOLD;
        bus.ram_we  = mapped && is_mem && !is_read;
        bus.io_wr   = mapped && !is_mem && !is_read;
        bus.io_rd   = mapped && !is_mem && is_read;
        bus.bus_err = ill_err || !mapped;
      end
      ST_HOLD: begin
        if (bus.nRD && bus.nWR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      is_read  <= 1'b0;
      is_mem   <= 1'b0;
      mapped   <= 1'b0;
      io_sel_q <= '0;
      d_out_q  <= 8'h00;
      d_oe_q   <= 1'b0;
      ill_seen <= 1'b0;
      ill_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      // A persistent illegal rd+wr request reports only once.
      ill_seen <= (state == ST_IDLE) && illegal;
      ill_err  <= (state == ST_IDLE) && illegal && !ill_seen;
      if (state == ST_IDLE && start) begin
        addr_q   <= bus.A[RAM_AW-1:0];
        is_read  <= !bus.nRD;
        is_mem   <= mem_kind;
        mapped   <= mem_kind ? mem_hit : io_hit;
        io_sel_q <= mem_kind ? '0 : sel_new;
      end
      if (state == ST_ACCESS && is_read) begin
        d_oe_q  <= 1'b1;
        d_out_q <= !mapped ? 8'hFF : (is_mem ? bus.ram_rdata : io_byte);
      end
      if (state == ST_HOLD && bus.nRD && bus.nWR) begin
        d_oe_q   <= 1'b0;
        io_sel_q <= '0;
      end
    end
  end

  assign bus.io_sel = io_sel_q;
  assign bus.d_out  = d_out_q;
  assign bus.d_oe   = d_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_host_bus_ctrl.sv
`default_nettype none
// ============================================================================
// tb_host_bus_ctrl : directed + random CPU cycles against a cycle-level model
// Rev 1.0
// ============================================================================
module tb_host_bus_ctrl;
  localparam int         RAM_AW   = 14;
  localparam int         NUM_IO   = 4;
  localparam logic [7:0] IO_BASE  = 8'h00;
  localparam int         MEM_WAIT = 0;
  localparam int         IO_WAIT  = 3;
  localparam int         RAM_SZ   = 1 << RAM_AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ram_init = 1'b0;
  logic [7:0] cpu_dout = 8'h00;
  logic [7:0] dev_ram [RAM_SZ];
  logic [7:0] ref_ram [RAM_SZ];
  logic [7:0] io_vals [NUM_IO];

  int total = 0;
  int bad = 0;
  int n_wait, n_we, n_rd, n_wr, n_err, n_oe;

  host_bus_if #(.RAM_AW(RAM_AW), .NUM_IO(NUM_IO)) bus ();

  host_bus_ctrl #(
    .RAM_AW(RAM_AW), .NUM_IO(NUM_IO), .IO_BASE(IO_BASE),
    .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Synchronous RAM device: data valid one clock after the address.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < RAM_SZ; i++) dev_ram[i] <= init_val(i);
    end else if (bus.ram_we) begin
      dev_ram[bus.ram_addr] <= cpu_dout;
    end
    bus.ram_rdata <= dev_ram[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    bus.nMREQ = 1'b1; bus.nIORQ = 1'b1; bus.nRD = 1'b1;
    bus.nWR = 1'b1; bus.nM1 = 1'b1; bus.nRFSH = 1'b1;
  endtask

  task automatic clear_counts();
    n_wait = 0; n_we = 0; n_rd = 0; n_wr = 0; n_err = 0; n_oe = 0;
  endtask

  task automatic sample();
    if (!bus.nWAIT) n_wait++;
    if (bus.ram_we) n_we++;
    if (bus.io_rd)  n_rd++;
    if (bus.io_wr)  n_wr++;
    if (bus.bus_err) n_err++;
    if (bus.d_oe)   n_oe++;
  endtask

  task automatic set_io_vals();
    for (int p = 0; p < NUM_IO; p++) begin
      io_vals[p] = 8'($urandom);
      bus.io_rdata[8*p +: 8] = io_vals[p];
    end
  endtask

  // One CPU cycle; the CPU releases its strobes after seeing nWAIT high for
  // 'hold' consecutive clocks, so d_oe should be visible for hold-1 clocks.
  task automatic do_cycle(input bit mem, input bit rd, input logic [15:0] addr,
                          input logic [7:0] wdata, input int hold);
    int port, waits, cyc, high_run, sel_bad;
    bit hit;
    logic [NUM_IO-1:0] exp_sel;
    logic [7:0] exp_data, last_dout;
    logic [RAM_AW-1:0] acc_addr;
    port  = int'(addr[15:8]);
    hit   = mem ? (int'(addr) < RAM_SZ)
                : (port >= int'(IO_BASE) && port < int'(IO_BASE) + NUM_IO);
    waits = mem ? MEM_WAIT : IO_WAIT;
    exp_sel = (!mem && hit) ? (NUM_IO'(1) << (port - int'(IO_BASE))) : '0;
    set_io_vals();
    if (!hit)     exp_data = 8'hFF;
    else if (mem) exp_data = ref_ram[addr[RAM_AW-1:0]];
    else          exp_data = io_vals[port - int'(IO_BASE)];
    if (mem && !rd && hit) ref_ram[addr[RAM_AW-1:0]] = wdata;

    bus.A = addr;
    cpu_dout = wdata;
    if (mem) bus.nMREQ = 1'b0; else bus.nIORQ = 1'b0;
    if (rd)  bus.nRD = 1'b0;   else bus.nWR = 1'b0;
    clear_counts();
    cyc = 0; high_run = 0; sel_bad = 0;
    last_dout = 8'h00; acc_addr = '0;
    while (high_run < hold && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) bus.A = 16'($urandom);
      sample();
      if (bus.io_sel !== exp_sel) sel_bad++;
      if (bus.nWAIT) high_run++; else high_run = 0;
      if (bus.nWAIT && high_run == 1) acc_addr = bus.ram_addr;
      if (bus.d_oe) last_dout = bus.d_out;
    end
    idle_pins();
    tick();
    sample();
    chk("cycle_ends", 32'(cyc < 100), 32'd1);
    chk("wait_clks", n_wait, waits);
    chk("ram_we_cnt", n_we, 32'(mem && !rd && hit));
    chk("io_rd_cnt", n_rd, 32'(!mem && rd && hit));
    chk("io_wr_cnt", n_wr, 32'(!mem && !rd && hit));
    chk("bus_err_cnt", n_err, 32'(!hit));
    chk("io_sel_bad_clks", sel_bad, 0);
    chk("d_oe_clks", n_oe, rd ? hold - 1 : 0);
    if (rd) chk("d_out", last_dout, exp_data);
    if (mem && hit) chk("ram_addr", acc_addr, addr[RAM_AW-1:0]);
    chk("d_oe_after", bus.d_oe, 1'b0);
    chk("io_sel_after", bus.io_sel, '0);
  endtask

  // Drives a non-cycle pin pattern for a few clocks; nothing may happen.
  task automatic quiet_cycle(input string tag, input bit mreq, input bit iorq,
                             input bit m1, input bit rfsh, input int exp_err);
    bus.A = 16'h0010;
    bus.nMREQ = mreq; bus.nIORQ = iorq; bus.nM1 = m1; bus.nRFSH = rfsh;
    bus.nRD = 1'b0;
    if (exp_err != 0) bus.nWR = 1'b0;
    clear_counts();
    for (int i = 0; i < 4; i++) begin tick(); sample(); end
    idle_pins();
    for (int i = 0; i < 2; i++) begin tick(); sample(); end
    chk({tag, "_strobes"}, n_we + n_rd + n_wr, 0);
    chk({tag, "_wait"}, n_wait, 0);
    chk({tag, "_d_oe"}, n_oe, 0);
    chk({tag, "_bus_err"}, n_err, exp_err);
  endtask

  initial begin
    logic [15:0] a;
    bit m, r;
    idle_pins();
    bus.A = 16'h0000;
    bus.io_rdata = '0;
    for (int i = 0; i < RAM_SZ; i++) ref_ram[i] = init_val(i);
    reset = 1'b1;
    ram_init = 1'b1;
    tick(); tick();
    ram_init = 1'b0;
    chk("rst_nWAIT", bus.nWAIT, 1'b1);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_io_rd", bus.io_rd, 1'b0);
    chk("rst_io_wr", bus.io_wr, 1'b0);
    chk("rst_bus_err", bus.bus_err, 1'b0);
    chk("rst_io_sel", bus.io_sel, '0);
    chk("rst_d_oe", bus.d_oe, 1'b0);
    chk("rst_d_out", bus.d_out, 8'h00);
    reset = 1'b0;
    tick();

    do_cycle(1'b1, 1'b0, 16'h0123, 8'h5A, 2);
    do_cycle(1'b1, 1'b1, 16'h0123, 8'h00, 3);
    chk("ram_content", dev_ram[14'h0123], 8'h5A);
    do_cycle(1'b0, 1'b1, 16'h0200, 8'h00, 2);
    do_cycle(1'b1, 1'b1, 16'h8000, 8'h00, 2);
    do_cycle(1'b1, 1'b0, 16'h4000, 8'h77, 2);
    do_cycle(1'b0, 1'b0, 16'h0700, 8'h11, 2);
    do_cycle(1'b0, 1'b1, 16'h03FF, 8'h00, 11);

    quiet_cycle("refresh", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    quiet_cycle("inta", 1'b1, 1'b0, 1'b0, 1'b1, 0);
    quiet_cycle("rd_wr_both", 1'b0, 1'b1, 1'b1, 1'b1, 1);

    // Reset during the wait states of an IO write.
    clear_counts();
    bus.A = 16'h0100; bus.nIORQ = 1'b0; bus.nWR = 1'b0;
    tick(); sample();
    chk("midrst_in_wait", bus.nWAIT, 1'b0);
    reset = 1'b1;
    idle_pins();
    tick(); sample();
    chk("midrst_nWAIT", bus.nWAIT, 1'b1);
    chk("midrst_io_sel", bus.io_sel, '0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); sample(); end
    chk("midrst_io_wr", n_wr, 0);
    chk("midrst_bus_err", n_err, 0);

    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (m) a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      else   a = {8'($urandom_range(0, 7)), 8'($urandom)};
      do_cycle(m, r, a, 8'($urandom), int'($urandom_range(2, 6)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
